ps2_host_tx: RTL

- PS/2 host-to-device transmitter: the host side that sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Counterpart of the existing PS/2 keyboard receiver; sits beside it in SimTop and shares the same ps2_clk/ps2_data pins.
- Drives both lines open-drain: each line is either pulled low or released.
- Implements inhibit, request-to-send, serialization on device clock edges, parity, stop and device ACK check.

---
 rtl/ps2_host_tx.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Holds the clock low to inhibit the device, issues request-to-send, then
// shifts out start/data/parity/stop on device clock falls and checks the
// device ACK. Both PS/2 lines are driven open-drain through the *_low outputs.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   tx_valid, tx_data   command byte handshake in; tx_ready out (IDLE only)
//   ps2_clk, ps2_data   raw line levels (asynchronous)
//   ps2_clk_low         1 = pull PS/2 clock low, 0 = release
//   ps2_data_low        1 = pull PS/2 data low, 0 = release
//   busy                high in every state except IDLE
//   tx_done             one-cycle pulse: frame sent and ACK seen
//   tx_err/tx_err_code  one-cycle pulse; code 01 = no ACK, 10 = timeout
//
// Optional feature: define PS2_TX_TIMEOUT_EN to abort a transfer that has not
// completed TIMEOUT_CYCLES after the clock line is released.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] tx_err_code
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_XFER, S_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [2:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_low_q, clk_low_d;
  logic             data_low_q, data_low_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             fall_c, data_sync_c, accept_c, inh_done_c, timeout_c;

  // Line synchronizers; a third clock stage yields a one-cycle fall strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign fall_c      = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_sync_c = data_sync_q[1];
  assign accept_c    = tx_valid & ready_q;
  assign inh_done_c  = (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Cleared on entry to XFER, counts every cycle the device owns the clock.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == S_RTS) begin
      to_cnt_d = '0;
    end else if (state_q == S_XFER || state_q == S_ACK) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end

  assign timeout_c = (state_q == S_XFER || state_q == S_ACK) &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    inh_cnt_d = inh_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d   = S_INHIBIT;
          shift_d   = tx_data;
          parity_d  = ~^tx_data;
          inh_cnt_d = '0;
        end
      end
      S_INHIBIT: begin
        if (inh_done_c) state_d = S_RTS;
        else            inh_cnt_d = inh_cnt_q + INH_W'(1);
      end
      S_RTS: begin
        state_d  = S_XFER;
        bitcnt_d = '0;
      end
      S_XFER: begin
        if (timeout_c) begin
          state_d = S_IDLE;
        end else if (fall_c) begin
          bitcnt_d = (bitcnt_q == 4'hF) ? bitcnt_q : bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall_c || timeout_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values; registered below so every port is a flop.
  always_comb begin
    clk_low_d  = 1'b0;
    data_low_d = data_low_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    code_d     = 2'b00;
    case (state_q)
      S_IDLE: begin
        data_low_d = 1'b0;
        clk_low_d  = accept_c;
      end
      S_INHIBIT: begin
        clk_low_d  = 1'b1;
        data_low_d = inh_done_c;  // start bit goes out with the RTS cycle
      end
      S_RTS: data_low_d = 1'b1;
      S_XFER: begin
        if (timeout_c) begin
          data_low_d = 1'b0;
          err_d      = 1'b1;
          code_d     = 2'b10;
        end else if (fall_c) begin
          if (bitcnt_q < 4'd8)       data_low_d = ~shift_q[bitcnt_q[2:0]];
          else if (bitcnt_q == 4'd8) data_low_d = ~parity_q;
          else                       data_low_d = 1'b0;
        end
      end
      S_ACK: begin
        data_low_d = 1'b0;
        if (fall_c) begin
          if (!data_sync_c) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end
        end else if (timeout_c) begin
          err_d  = 1'b1;
          code_d = 2'b10;
        end
      end
      default: data_low_d = 1'b0;
    endcase
    busy_d  = (state_d != S_IDLE);
    // Ready reopens one cycle after the completion pulse.
    ready_d = (state_d == S_IDLE) && !done_d && !err_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      bitcnt_q   <= '0;
      inh_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      bitcnt_q   <= bitcnt_d;
      inh_cnt_q  <= inh_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign tx_ready     = ready_q;
  assign ps2_clk_low  = clk_low_q;
  assign ps2_data_low = data_low_q;
  assign busy         = busy_q;
  assign tx_done      = done_q;
  assign tx_err       = err_q;
  assign tx_err_code  = code_q;

endmodule
